// File: rtl/if_stage_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, PC step,
// FSM state encoding and a PC increment helper.
package if_stage_unit_pkg;

    localparam int unsigned XLEN = 32;   // address width
    localparam int unsigned ILEN = 32;   // instruction width

    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    // Sequential PC step; wraps modulo 2^32 with no error indication.
    function automatic logic [XLEN-1:0] pc_plus_inc(input logic [XLEN-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_stage_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage (master)
// and the instruction memory (slave). Zero-wait: ack may arrive in the
// same cycle as req.
interface if_stage_unit_if;
    import if_stage_unit_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_stage_unit_if_id_reg.sv
// IF/ID pipeline register. Priority: flush > hold > load; with none of
// them asserted the register takes a bubble (valid cleared).
module if_id_reg
    import if_stage_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            hold,
    input  logic [XLEN-1:0] load_pc,
    input  logic [ILEN-1:0] load_instr,
    output logic [XLEN-1:0] pc,
    output logic [ILEN-1:0] instr,
    output logic            valid
);

    // IF/ID state update with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= '0;
            instr <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            pc    <= '0;
            instr <= '0;
            valid <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                pc    <= load_pc;
                instr <= load_instr;
                valid <= 1'b1;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: PC, fetch FSM, one-entry skid buffer for
// fetches that complete under a hazard, and a redirect register for
// branches that resolve while a fetch is still outstanding.
// Optional feature: define IF_STALL_COUNT_EN to add the stall_count port.
module if_stage_unit
    import if_stage_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hazard,
    input  logic                branch_taken,
    input  logic [XLEN-1:0]     branch_addr,
    if_stage_unit_if.master     imem,
    output logic [XLEN-1:0]     if_id_pc,
    output logic [ILEN-1:0]     if_id_instr,
    output logic                if_id_valid
`ifdef IF_STALL_COUNT_EN
    ,output logic [15:0]        stall_count
`endif
);

    fetch_state_t    state;
    fetch_state_t    next_state;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4;

    logic [XLEN-1:0] skid_pc;
    logic [ILEN-1:0] skid_instr;
    logic            skid_we;
    logic            skid_clr;

    logic [XLEN-1:0] redirect;
    logic            redirect_we;

    logic            id_load;
    logic            id_flush;
    logic            id_hold;
    logic [XLEN-1:0] id_load_pc;
    logic [ILEN-1:0] id_load_instr;

    assign pc_plus4 = pc_plus_inc(pc);

    // Request depends only on state, so reset drops it immediately.
    assign imem.imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem.imem_addr = pc;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, PC selection and IF/ID / skid / redirect controls
    always_comb begin
        next_state    = state;
        pc_next       = pc;
        skid_we       = 1'b0;
        skid_clr      = 1'b0;
        redirect_we   = 1'b0;
        id_load       = 1'b0;
        id_flush      = 1'b0;
        id_hold       = 1'b0;
        id_load_pc    = pc_plus4;
        id_load_instr = imem.imem_rdata;

        case (state)
            IDLE: begin
                next_state = FETCH;
                if (branch_taken) begin
                    pc_next  = branch_addr;
                    id_flush = 1'b1;
                end else begin
                    id_hold = 1'b1;
                end
            end

            FETCH: begin
                if (branch_taken) begin
                    id_flush = 1'b1;
                    skid_clr = 1'b1;
                    if (imem.imem_ack) begin
                        pc_next = branch_addr;
                    end else begin
                        redirect_we = 1'b1;
                        next_state  = DRAIN;
                    end
                end else if (imem.imem_ack) begin
                    pc_next = pc_plus4;
                    if (hazard) begin
                        skid_we    = 1'b1;
                        id_hold    = 1'b1;
                        next_state = HOLD;
                    end else begin
                        id_load = 1'b1;
                    end
                end else if (hazard) begin
                    id_hold = 1'b1;
                end
                // ack=0, hazard=0: no control asserted -> IF/ID bubble
            end

            HOLD: begin
                if (branch_taken) begin
                    pc_next    = branch_addr;
                    id_flush   = 1'b1;
                    skid_clr   = 1'b1;
                    next_state = FETCH;
                end else if (hazard) begin
                    id_hold = 1'b1;
                end else begin
                    id_load       = 1'b1;
                    id_load_pc    = skid_pc;
                    id_load_instr = skid_instr;
                    next_state    = FETCH;
                end
            end

            DRAIN: begin
                id_flush = 1'b1;
                if (branch_taken) begin
                    redirect_we = 1'b1;
                end
                // A branch arriving together with the ack wins over the
                // stored target, since it is the newest redirect.
                if (imem.imem_ack) begin
                    pc_next    = branch_taken ? branch_addr : redirect;
                    next_state = FETCH;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // PC, skid buffer and redirect register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            skid_pc    <= '0;
            skid_instr <= '0;
            redirect   <= '0;
        end else begin
            pc <= pc_next;
            if (skid_clr) begin
                skid_pc    <= '0;
                skid_instr <= '0;
            end else if (skid_we) begin
                skid_pc    <= pc_plus4;
                skid_instr <= imem.imem_rdata;
            end
            if (redirect_we) begin
                redirect <= branch_addr;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (id_load),
        .flush      (id_flush),
        .hold       (id_hold),
        .load_pc    (id_load_pc),
        .load_instr (id_load_instr),
        .pc         (if_id_pc),
        .instr      (if_id_instr),
        .valid      (if_id_valid)
    );

`ifdef IF_STALL_COUNT_EN
    // Saturating count of cycles spent under a hazard without a redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (hazard && !branch_taken && (stall_count != '1)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage_unit.sv
// Directed bench for if_stage_unit: a vector table for the main fetch
// sequences plus hand-written sequences for wrap, DRAIN retargeting and
// asynchronous reset. Instruction memory returns 0xE0810002 + address.
module tb_if_stage_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        ack_v = 1'b0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
`ifdef IF_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    if_stage_unit_if mem ();

    assign mem.imem_ack   = ack_v;
    assign mem.imem_rdata = 32'hE081_0002 + mem.imem_addr;

    if_stage_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (mem),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid)
`ifdef IF_STALL_COUNT_EN
        ,.stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        h;
        logic        b;
        logic        ack;
        logic [31:0] baddr;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic        chk_id;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic h, input logic b, input logic ack,
                       input logic [31:0] baddr, input logic req,
                       input logic [31:0] addr, input logic valid,
                       input logic chk_id, input logic [31:0] pc,
                       input logic [31:0] instr);
        vec_t v;
        v.h = h; v.b = b; v.ack = ack; v.baddr = baddr;
        v.req = req; v.addr = addr; v.valid = valid;
        v.chk_id = chk_id; v.pc = pc; v.instr = instr;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic b, input logic ack,
                         input logic [31:0] baddr);
        hazard = h; branch_taken = b; ack_v = ack; branch_addr = baddr;
    endtask

    task automatic chk_out(input string tag, input logic req,
                           input logic [31:0] addr, input logic valid);
        chk({tag, " req"},   {31'd0, mem.imem_req}, {31'd0, req});
        chk({tag, " addr"},  mem.imem_addr, addr);
        chk({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc,
                          input logic [31:0] instr);
        chk({tag, " if_id_pc"},    if_id_pc, pc);
        chk({tag, " if_id_instr"}, if_id_instr, instr);
    endtask

    initial begin
        // h b ack baddr        | req addr         valid chk pc           instr
        add(0,0,1,32'h0,          1, 32'h0000_0000, 0, 1, 32'h0,         32'h0);          // IDLE -> FETCH
        add(0,0,1,32'h0,          1, 32'h0000_0004, 1, 1, 32'h4,         32'hE081_0002);
        add(0,0,1,32'h0,          1, 32'h0000_0008, 1, 1, 32'h8,         32'hE081_0006);
        add(1,0,1,32'h0,          0, 32'h0000_000C, 1, 1, 32'h8,         32'hE081_0006);  // skid, HOLD
        add(1,0,1,32'h0,          0, 32'h0000_000C, 1, 1, 32'h8,         32'hE081_0006);
        add(1,0,1,32'h0,          0, 32'h0000_000C, 1, 1, 32'h8,         32'hE081_0006);
        add(0,0,1,32'h0,          1, 32'h0000_000C, 1, 1, 32'hC,         32'hE081_000A);  // from skid
        add(0,0,1,32'h0,          1, 32'h0000_0010, 1, 1, 32'h10,        32'hE081_000E);
        add(1,1,1,32'h100,        1, 32'h0000_0100, 0, 0, 32'h0,         32'h0);          // branch beats hazard
        add(0,0,1,32'h0,          1, 32'h0000_0104, 1, 1, 32'h104,       32'hE081_0102);
        add(0,0,1,32'h0,          1, 32'h0000_0108, 1, 1, 32'h108,       32'hE081_0106);
        add(0,0,1,32'h0,          1, 32'h0000_010C, 1, 1, 32'h10C,       32'hE081_010A);
        add(0,0,0,32'h0,          1, 32'h0000_010C, 0, 0, 32'h0,         32'h0);          // ack withheld x4
        add(0,0,0,32'h0,          1, 32'h0000_010C, 0, 0, 32'h0,         32'h0);
        add(0,0,0,32'h0,          1, 32'h0000_010C, 0, 0, 32'h0,         32'h0);
        add(0,0,0,32'h0,          1, 32'h0000_010C, 0, 0, 32'h0,         32'h0);
        add(0,1,0,32'h200,        1, 32'h0000_010C, 0, 0, 32'h0,         32'h0);          // -> DRAIN
        add(0,0,0,32'h0,          1, 32'h0000_010C, 0, 0, 32'h0,         32'h0);
        add(0,0,1,32'h0,          1, 32'h0000_0200, 0, 0, 32'h0,         32'h0);          // data dropped
        add(0,0,1,32'h0,          1, 32'h0000_0204, 1, 1, 32'h204,       32'hE081_0202);
        add(1,0,0,32'h0,          1, 32'h0000_0204, 1, 1, 32'h204,       32'hE081_0202);  // hazard, no ack
        add(0,0,1,32'h0,          1, 32'h0000_0208, 1, 1, 32'h208,       32'hE081_0206);
        add(1,0,1,32'h0,          0, 32'h0000_020C, 1, 1, 32'h208,       32'hE081_0206);  // skid, HOLD
        add(1,1,0,32'h300,        1, 32'h0000_0300, 0, 0, 32'h0,         32'h0);          // branch in HOLD
        add(0,0,1,32'h0,          1, 32'h0000_0304, 1, 1, 32'h304,       32'hE081_0302);  // skid discarded

        // Asynchronous reset
        #2 rst = 1'b0;
        #1;
        chk_out("reset", 1'b0, 32'h0, 1'b0);
        chk_id("reset", 32'h0, 32'h0);
        step();
        rst = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].h, vq[i].b, vq[i].ack, vq[i].baddr);
            step();
            chk_out($sformatf("vec%0d", i), vq[i].req, vq[i].addr, vq[i].valid);
            if (vq[i].chk_id)
                chk_id($sformatf("vec%0d", i), vq[i].pc, vq[i].instr);
        end

        // PC wrap at the top of the address space
        drive(0, 1, 1, 32'hFFFF_FFFC);
        step();
        chk_out("wrap0", 1'b1, 32'hFFFF_FFFC, 1'b0);
        drive(0, 0, 1, 32'h0);
        step();
        chk_out("wrap1", 1'b1, 32'h0000_0000, 1'b1);
        chk_id("wrap1", 32'h0, 32'hE080_FFFE);
        step();
        chk_out("wrap2", 1'b1, 32'h0000_0004, 1'b1);
        chk_id("wrap2", 32'h4, 32'hE081_0002);

        // Second branch in DRAIN overwrites the pending target
        drive(0, 1, 0, 32'h400);
        step();
        chk_out("drain0", 1'b1, 32'h4, 1'b0);
        drive(0, 1, 0, 32'h500);
        step();
        chk_out("drain1", 1'b1, 32'h4, 1'b0);
        drive(0, 0, 1, 32'h0);
        step();
        chk_out("drain2", 1'b1, 32'h500, 1'b0);
        step();
        chk_out("drain3", 1'b1, 32'h504, 1'b1);
        chk_id("drain3", 32'h504, 32'hE081_0502);

        // Reset asserted mid-DRAIN with a late ack present
        drive(0, 1, 0, 32'h600);
        step();
        chk_out("rstdrain0", 1'b1, 32'h504, 1'b0);
        drive(0, 0, 1, 32'h0);
        #3 rst = 1'b0;
        #1;
        chk_out("rstdrain_async", 1'b0, 32'h0, 1'b0);
        chk_id("rstdrain_async", 32'h0, 32'h0);
        step();
        chk_out("rstdrain_held", 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        chk_out("rstdrain_idle", 1'b1, 32'h0, 1'b0);
        step();
        chk_out("rstdrain_fetch", 1'b1, 32'h4, 1'b1);
        chk_id("rstdrain_fetch", 32'h4, 32'hE081_0002);

`ifdef IF_STALL_COUNT_EN
        rst = 1'b0;
        #1 rst = 1'b1;
        drive(1, 0, 1, 32'h0);
        for (int unsigned k = 0; k < 5; k++) step();
        chk("stall_count", {16'd0, stall_count}, 32'd5);
        drive(0, 0, 1, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
